// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state encoding, BCD constants and digit check for the BCD datapath
package bcd_pkg;
   typedef enum logic [1:0] {S_IDLE, S_SUB, S_COMP, S_DONE} state_t;
   localparam logic [3:0] BCD_MAX   = 4'd9;
   localparam logic [3:0] BCD_RADIX = 4'd10;
   function automatic logic digit_ok(input logic [3:0] d);
      return d <= BCD_MAX;
   endfunction
endpackage

// File: rtl/bcd_serial_sub_if.sv
// bcd_serial_sub_if: start/busy/done handshake plus operand and result buses
interface bcd_serial_sub_if #(parameter int DIGITS = 4);
   logic                start;
   logic [4*DIGITS-1:0] a;
   logic [4*DIGITS-1:0] b;
   logic                busy;
   logic                done;
   logic [4*DIGITS-1:0] diff;
   logic                neg;
   logic                invalid;
   modport master(output start, a, b, input busy, done, diff, neg, invalid);
   modport slave(input start, a, b, output busy, done, diff, neg, invalid);
endinterface

// File: rtl/bcd_digit_sub.sv
// bcd_digit_sub: one BCD digit x - y - bin, result folded back into 0..9 with borrow out
module bcd_digit_sub
   import bcd_pkg::*;
(
   input  logic [3:0] x_i,
   input  logic [3:0] y_i,
   input  logic       bin_i,
   output logic [3:0] d_o,
   output logic       bout_o
);
   logic [4:0] t;
   assign t      = {1'b0, x_i} - {1'b0, y_i} - {4'd0, bin_i};
   assign bout_o = t[4];
   assign d_o    = t[4] ? t[3:0] + BCD_RADIX : t[3:0];
endmodule

// File: rtl/bcd_serial_sub.sv
// bcd_serial_sub: digit-serial packed-BCD |a-b| with sign, ten's-complement fixup pass when a<b
module bcd_serial_sub
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input logic clk,
   input logic rst,
   bcd_serial_sub_if.slave bus
);
   localparam int W  = 4 * DIGITS;
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
   state_t        state_q;
   logic [W-1:0]  a_q, b_q, diff_q;
   logic [IW-1:0] idx_q;
   logic          borrow_q, neg_q, invalid_q, done_q, bad;
   logic [3:0]    x, y, d;
   logic          bout;
   // flag any non-BCD digit on the operands being accepted
   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         if (!digit_ok(bus.a[4*i +: 4]) || !digit_ok(bus.b[4*i +: 4])) bad = 1'b1;
   end
   // SUB works on the latched operands; COMP negates the partial result (0 - diff)
   assign x = state_q == S_SUB ? a_q[4*idx_q +: 4] : 4'd0;
   assign y = state_q == S_SUB ? b_q[4*idx_q +: 4] : diff_q[4*idx_q +: 4];
   bcd_digit_sub u_dig (.x_i(x), .y_i(y), .bin_i(borrow_q), .d_o(d), .bout_o(bout));
   assign bus.busy    = state_q != S_IDLE;
   assign bus.done    = done_q;
   assign bus.diff    = diff_q;
   assign bus.neg     = neg_q;
   assign bus.invalid = invalid_q;
   // control FSM and result registers; done is raised on entry to DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         diff_q    <= '0;
         idx_q     <= '0;
         borrow_q  <= 1'b0;
         neg_q     <= 1'b0;
         invalid_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: if (bus.start) begin
               a_q       <= bus.a;
               b_q       <= bus.b;
               diff_q    <= '0;
               idx_q     <= '0;
               borrow_q  <= 1'b0;
               neg_q     <= 1'b0;
               invalid_q <= bad;
               done_q    <= bad;
               state_q   <= bad ? S_DONE : S_SUB;
            end
            S_SUB, S_COMP: begin
               diff_q[4*idx_q +: 4] <= d;
               borrow_q             <= bout;
               idx_q                <= idx_q + 1'b1;
               if (idx_q == LAST) begin
                  idx_q    <= '0;
                  borrow_q <= 1'b0;
                  if (state_q == S_SUB && bout) begin
                     state_q <= S_COMP;
                     neg_q   <= 1'b1;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bcd_serial_sub.sv
// tb_bcd_serial_sub: vector table, random ops against a decimal model, handshake and reset corners
module tb_bcd_serial_sub;
   localparam int D = 4;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   pass_cnt = 0;
   int   chk_cnt = 0;
   typedef struct {
      logic [15:0] a, b, diff;
      logic        neg, inv;
      int          lat;
   } vec_t;
   vec_t tbl[$];
   bcd_serial_sub_if #(.DIGITS(D)) bus();
   bcd_serial_sub #(.DIGITS(D)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h required %0h", nm, act, exp);
   endtask
   function automatic vec_t model(input logic [15:0] a, input logic [15:0] b);
      vec_t r;
      int   av, bv, dv;
      av = 0;
      bv = 0;
      r.a = a;
      r.b = b;
      r.inv = 1'b0;
      r.neg = 1'b0;
      r.diff = '0;
      for (int i = D - 1; i >= 0; i--) begin
         if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) r.inv = 1'b1;
         av = av * 10 + int'(a[4*i +: 4]);
         bv = bv * 10 + int'(b[4*i +: 4]);
      end
      if (r.inv) r.lat = 1;
      else begin
         r.neg = av < bv;
         dv = r.neg ? bv - av : av - bv;
         for (int i = 0; i < D; i++) begin
            r.diff[4*i +: 4] = 4'(dv % 10);
            dv = dv / 10;
         end
         r.lat = r.neg ? 2 * D + 1 : D + 1;
      end
      return r;
   endfunction
   task automatic run_op(input vec_t v, input string nm);
      int c;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = v.a;
      bus.b = v.b;
      @(negedge clk);
      bus.start = 1'b0;
      c = 1;
      chk({nm, " busy"}, 32'(bus.busy), 32'd1);
      while (!bus.done && c < 30) begin
         bus.a = 16'($urandom);
         bus.b = 16'($urandom);
         @(negedge clk);
         c++;
      end
      chk({nm, " latency"}, c, v.lat);
      chk({nm, " diff"}, 32'(bus.diff), 32'(v.diff));
      chk({nm, " neg/invalid"}, {30'd0, bus.neg, bus.invalid}, {30'd0, v.neg, v.inv});
      @(negedge clk);
      chk({nm, " idle after done"}, {30'd0, bus.busy, bus.done}, 32'd0);
   endtask
   initial begin
      int d1, d2, extra, dn;
      logic [15:0] ra, rb;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      #1 rst = 1'b1;
      #1;
      chk("reset outputs", {bus.busy, bus.done, bus.neg, bus.invalid, bus.diff}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tbl.push_back('{16'h1234, 16'h0567, 16'h0667, 1'b0, 1'b0, 5});
      tbl.push_back('{16'h0100, 16'h0250, 16'h0150, 1'b1, 1'b0, 9});
      tbl.push_back('{16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, 5});
      tbl.push_back('{16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 9});
      tbl.push_back('{16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 1});
      tbl.push_back('{16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 9});
      tbl.push_back('{16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 5});
      tbl.push_back('{16'h0000, 16'hF000, 16'h0000, 1'b0, 1'b1, 1});
      tbl.push_back('{16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 5});
      foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < D; i++) begin
            ra[4*i +: 4] = 4'($urandom_range(0, 9));
            rb[4*i +: 4] = 4'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 7) == 0) rb = ra;
         if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
         run_op(model(ra, rb), $sformatf("rnd%0d %h-%h", n, ra, rb));
      end
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = 16'h1234;
      bus.b = 16'h0567;
      d1 = -1;
      d2 = -1;
      extra = 0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (bus.done) begin
            if (d1 < 0) begin
               d1 = c;
               chk("held start first diff", {bus.neg, bus.invalid, 14'd0, bus.diff}, 32'h0000_0667);
            end else if (d2 < 0) begin
               d2 = c;
               chk("held start second diff", {bus.neg, bus.invalid, 14'd0, bus.diff}, 32'h8000_0001);
            end else extra++;
         end
         if (c == 6) chk("held start idle gap", 32'(bus.busy), 32'd0);
         if (c < 5) begin
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
         end
         if (c == 5) begin
            bus.a = 16'h0000;
            bus.b = 16'h0001;
         end
         if (c == 15) bus.start = 1'b0;
      end
      chk("held start first done cycle", d1, 5);
      chk("held start second done cycle", d2, 15);
      chk("held start extra dones", extra, 0);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = 16'h0100;
      bus.b = 16'h0250;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort outputs", {bus.busy, bus.done, bus.neg, bus.invalid, bus.diff}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done) dn++;
      end
      chk("abort no done", dn, 0);
      run_op(model(16'h0100, 16'h0250), "after abort");
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
